ring_rotate_sequencer: RTL and testbench

- Command-driven controller that owns and sequences a WIDTH-bit ring (rotate) register.
- The register supports load, clear-to-one-hot, and rotate-left/right by a programmed number of steps.
- A programmable inter-step dwell time spaces the rotations.
- Sits between a stimulus/control master (valid/ready command port) and logic consuming the ring value; reports busy, per-step and completion pulses.

---
 rtl/ring_rotate_sequencer_if.sv | 28 ++
 rtl/ring_rotate_sequencer.sv | 119 +++++++++++
 tb/tb_ring_rotate_sequencer.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/ring_rotate_sequencer_if.sv
// Command port of the ring rotate sequencer: one command per valid/ready
// handshake, plus a level-sensitive abort that only matters while rotating.
interface ring_rotate_sequencer_if #(
    parameter int WIDTH  = 4,
    parameter int STEP_W = 4,
    parameter int CNT_W  = 8
);
    // Handshake: a command transfers on a rising edge where cmd_valid and
    // cmd_ready are both high; cmd_ready depends on controller state only,
    // and the master holds cmd_* stable while cmd_valid waits for cmd_ready.
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [WIDTH-1:0]  cmd_data;
    logic [STEP_W-1:0] cmd_steps;
    logic [CNT_W-1:0]  interval;
    logic              abort;

    modport master (
        output cmd_valid, cmd_op, cmd_data, cmd_steps, interval, abort,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, cmd_steps, interval, abort,
        output cmd_ready
    );
endinterface

// File: rtl/ring_rotate_sequencer.sv
// Command-driven owner of a WIDTH-bit ring register: load, clear to one-hot,
// and rotate left/right a programmed number of steps with a dwell between steps.
module ring_rotate_sequencer #(
    parameter int WIDTH  = 4,
    parameter int STEP_W = 4,
    parameter int CNT_W  = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    ring_rotate_sequencer_if.slave bus,
    output logic [WIDTH-1:0]       count,
    output logic                   busy,
    output logic                   step_pulse,
    output logic                   done,
    output logic [1:0]             dbg_state_o
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_LEFT  = 2'b01;
    localparam logic [1:0] OP_RIGHT = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    localparam logic [WIDTH-1:0] ONE_HOT = {{(WIDTH-1){1'b0}}, 1'b1};

    state_e            state_q;
    logic [WIDTH-1:0]  count_q;
    logic [WIDTH-1:0]  count_rot_d;
    logic [STEP_W-1:0] remaining_q;
    logic [CNT_W-1:0]  timer_q;
    logic [CNT_W-1:0]  interval_q;
    logic              dir_right_q;
    logic              step_pulse_q;
    logic              done_q;

    always_comb begin
        count_rot_d = count_q;
        if (dir_right_q) count_rot_d = {count_q[0], count_q[WIDTH-1:1]};
        else             count_rot_d = {count_q[WIDTH-2:0], count_q[WIDTH-1]};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            count_q      <= ONE_HOT;
            remaining_q  <= '0;
            timer_q      <= '0;
            interval_q   <= '0;
            dir_right_q  <= 1'b0;
            step_pulse_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            step_pulse_q <= 1'b0;
            done_q       <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.cmd_valid) begin
                        case (bus.cmd_op)
                            OP_LOAD: begin
                                count_q <= bus.cmd_data;
                                state_q <= S_DONE;
                                done_q  <= 1'b1;
                            end
                            OP_CLEAR: begin
                                count_q <= ONE_HOT;
                                state_q <= S_DONE;
                                done_q  <= 1'b1;
                            end
                            OP_LEFT, OP_RIGHT: begin
                                if (bus.cmd_steps == '0) begin
                                    state_q <= S_DONE;
                                    done_q  <= 1'b1;
                                end else begin
                                    dir_right_q <= (bus.cmd_op == OP_RIGHT);
                                    remaining_q <= bus.cmd_steps;
                                    timer_q     <= bus.interval;
                                    interval_q  <= bus.interval;
                                    state_q     <= S_RUN;
                                end
                            end
                            default: state_q <= S_IDLE;
                        endcase
                    end
                end
                S_RUN: begin
                    // Abort wins even over a step that is due on this edge.
                    if (bus.abort) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end else if (timer_q != '0) begin
                        timer_q <= timer_q - 1'b1;
                    end else begin
                        count_q      <= count_rot_d;
                        remaining_q  <= remaining_q - 1'b1;
                        timer_q      <= interval_q;
                        step_pulse_q <= 1'b1;
                        if (remaining_q == STEP_W'(1)) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.cmd_ready = (state_q == S_IDLE);
    assign busy          = (state_q != S_IDLE);
    assign count         = count_q;
    assign step_pulse    = step_pulse_q;
    assign done          = done_q;
    assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_ring_rotate_sequencer.sv
// Directed bench for ring_rotate_sequencer: commands are issued through the
// interface and every output is compared against hand-computed values.
module tb_ring_rotate_sequencer;
    localparam int WIDTH  = 4;
    localparam int STEP_W = 4;
    localparam int CNT_W  = 8;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_LEFT  = 2'b01;
    localparam logic [1:0] OP_RIGHT = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    logic             clk;
    logic             reset;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             step_pulse;
    logic             done;
    logic [1:0]       dbg_state;

    int n_total = 0;
    int n_bad   = 0;

    logic [WIDTH-1:0] exp_q[$];

    ring_rotate_sequencer_if #(.WIDTH(WIDTH), .STEP_W(STEP_W), .CNT_W(CNT_W)) bus ();

    ring_rotate_sequencer #(.WIDTH(WIDTH), .STEP_W(STEP_W), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .count       (count),
        .busy        (busy),
        .step_pulse  (step_pulse),
        .done        (done),
        .dbg_state_o (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Observation point: 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [WIDTH-1:0] data,
                         input logic [STEP_W-1:0] steps, input logic [CNT_W-1:0] intv);
        int w;
        w = 0;
        while (!bus.cmd_ready && w < 50) begin
            tick();
            w++;
        end
        chk("ready_wait", {31'd0, bus.cmd_ready}, 32'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_data  = data;
        bus.cmd_steps = steps;
        bus.interval  = intv;
        tick();
        // Scramble the fields after accept; the controller must not care.
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'b11;
        bus.cmd_data  = 4'b0110;
        bus.cmd_steps = 4'hF;
        bus.interval  = 8'h07;
    endtask

    task automatic load_and_settle(input logic [WIDTH-1:0] v);
        issue(OP_LOAD, v, '0, '0);
        tick();
    endtask

    // Runs a rotate command, watching until busy drops; exp_q holds the
    // hand-computed value expected at each step_pulse.
    task automatic rot_test(input string tag, input logic [1:0] op,
                            input logic [STEP_W-1:0] steps, input logic [CNT_W-1:0] intv,
                            input int abort_k, input int budget,
                            input int exp_steps, input int exp_first_k, input int exp_done_k,
                            input int exp_busy, input logic [WIDTH-1:0] exp_final);
        int k, n_steps, first_k, done_k, n_done, n_busy;
        k = 0; n_steps = 0; first_k = -1; done_k = -1; n_done = 0; n_busy = 0;
        issue(op, '0, steps, intv);
        while (k < budget) begin
            if (k == abort_k) bus.abort = 1'b1;
            if (busy) n_busy++;
            if (step_pulse) begin
                n_steps++;
                if (first_k < 0) first_k = k;
                if (exp_q.size() > 0) chk({tag, "_step_val"}, 32'(count), 32'(exp_q.pop_front()));
                else chk({tag, "_extra_step"}, 32'(n_steps), 32'(exp_steps));
            end
            if (done) begin
                n_done++;
                done_k = k;
            end
            if (!busy) break;
            tick();
            k++;
        end
        bus.abort = 1'b0;
        chk({tag, "_timeout"}, {31'd0, (k < budget)}, 32'd1);
        chk({tag, "_steps"}, 32'(n_steps), 32'(exp_steps));
        chk({tag, "_first_k"}, 32'(first_k), 32'(exp_first_k));
        chk({tag, "_done_k"}, 32'(done_k), 32'(exp_done_k));
        chk({tag, "_done_n"}, 32'(n_done), 32'd1);
        chk({tag, "_busy_n"}, 32'(n_busy), 32'(exp_busy));
        chk({tag, "_final"}, 32'(count), 32'(exp_final));
        chk({tag, "_ready"}, {31'd0, bus.cmd_ready}, 32'd1);
        chk({tag, "_leftover"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    logic [WIDTH-1:0] bb_cnt [9];
    logic             bb_rdy [9];

    initial begin
        reset         = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = OP_LOAD;
        bus.cmd_data  = '0;
        bus.cmd_steps = '0;
        bus.interval  = '0;
        bus.abort     = 1'b0;

        // Reset state, held and then released
        #12;
        chk("rst_count", 32'(count), 32'h1);
        chk("rst_ready", {31'd0, bus.cmd_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_state", 32'(dbg_state), 32'd0);
        #10 reset = 1'b1;
        tick();
        tick();
        chk("post_rst_count", 32'(count), 32'h1);
        chk("post_rst_busy", {31'd0, busy}, 32'd0);
        chk("post_rst_step", {31'd0, step_pulse}, 32'd0);

        // LOAD then CLEAR
        issue(OP_LOAD, 4'b1010, '0, '0);
        chk("load_count", 32'(count), 32'b1010);
        chk("load_done", {31'd0, done}, 32'd1);
        chk("load_ready", {31'd0, bus.cmd_ready}, 32'd0);
        chk("load_busy", {31'd0, busy}, 32'd1);
        tick();
        chk("load_done_off", {31'd0, done}, 32'd0);
        chk("load_ready_back", {31'd0, bus.cmd_ready}, 32'd1);
        chk("load_busy_off", {31'd0, busy}, 32'd0);
        issue(OP_CLEAR, '0, '0, '0);
        chk("clear_count", 32'(count), 32'b0001);
        chk("clear_done", {31'd0, done}, 32'd1);
        tick();
        chk("clear_done_off", {31'd0, done}, 32'd0);

        // ROT_LEFT 3, interval 0
        load_and_settle(4'b1000);
        exp_q.push_back(4'b0001); exp_q.push_back(4'b0010); exp_q.push_back(4'b0100);
        rot_test("rl3", OP_LEFT, 4'd3, 8'd0, -1, 50, 3, 1, 3, 4, 4'b0100);

        // ROT_RIGHT 2, interval 4
        load_and_settle(4'b0001);
        exp_q.push_back(4'b1000); exp_q.push_back(4'b0100);
        rot_test("rr2", OP_RIGHT, 4'd2, 8'd4, -1, 50, 2, 5, 10, 11, 4'b0100);

        // Abort right after the 2nd rotation
        load_and_settle(4'b0001);
        exp_q.push_back(4'b0010); exp_q.push_back(4'b0100);
        rot_test("abort_a", OP_LEFT, 4'd5, 8'd2, 6, 50, 2, 3, 7, 8, 4'b0100);

        // Abort present on the edge where the 3rd step is due
        load_and_settle(4'b0001);
        exp_q.push_back(4'b0010); exp_q.push_back(4'b0100);
        rot_test("abort_b", OP_LEFT, 4'd5, 8'd2, 8, 50, 2, 3, 9, 10, 4'b0100);

        // Zero steps
        rot_test("rl0", OP_LEFT, 4'd0, 8'd3, -1, 50, 0, -1, 0, 1, 4'b0100);

        // WIDTH steps restore the original value
        load_and_settle(4'b1010);
        exp_q.push_back(4'b0101); exp_q.push_back(4'b1010);
        exp_q.push_back(4'b0101); exp_q.push_back(4'b1010);
        rot_test("rl4", OP_LEFT, 4'd4, 8'd0, -1, 50, 4, 1, 4, 5, 4'b1010);

        // Maximum interval
        load_and_settle(4'b0100);
        exp_q.push_back(4'b0010);
        rot_test("rr_max", OP_RIGHT, 4'd1, 8'hFF, -1, 300, 1, 256, 256, 257, 4'b0010);

        // Back-to-back with cmd_valid held high
        load_and_settle(4'b0001);
        bb_cnt = '{4'b0001, 4'b0010, 4'b0010, 4'b0010, 4'b0100,
                   4'b0100, 4'b0100, 4'b1000, 4'b1000};
        bb_rdy = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = OP_LEFT;
        bus.cmd_steps = 4'd1;
        bus.interval  = 8'd0;
        for (int i = 0; i < 9; i++) begin
            tick();
            chk($sformatf("bb_count_%0d", i), 32'(count), 32'(bb_cnt[i]));
            chk($sformatf("bb_ready_%0d", i), {31'd0, bus.cmd_ready}, {31'd0, bb_rdy[i]});
        end
        bus.cmd_valid = 1'b0;

        // Asynchronous reset in the middle of a rotation
        issue(OP_LEFT, '0, 4'd4, 8'd3);
        for (int i = 0; i < 5; i++) tick();
        chk("mid_pre_count", 32'(count), 32'b0001);
        chk("mid_pre_busy", {31'd0, busy}, 32'd1);
        #3 reset = 1'b0;
        #1;
        chk("mid_rst_count", 32'(count), 32'b0001);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_ready", {31'd0, bus.cmd_ready}, 32'd1);
        chk("mid_rst_done", {31'd0, done}, 32'd0);
        #2 reset = 1'b1;
        tick();
        chk("mid_after_done", {31'd0, done}, 32'd0);
        chk("mid_after_busy", {31'd0, busy}, 32'd0);
        tick();
        chk("mid_after_done2", {31'd0, done}, 32'd0);
        chk("mid_after_count", 32'(count), 32'b0001);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
